// File: rtl/mem_wb_stage.sv
// Writeback stage of the RV32I core.
// Retires ALU results in one cycle, waits for data-memory responses on loads,
// extends the loaded byte/halfword, and drives a registered register-file
// write port. Load faults (illegal width code, misalignment, timeout) retire
// the instruction without writing and raise a sticky error flag.
module mem_wb_stage #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_pi,
    output logic                 ready_po,
    input  logic                 is_load_pi,
    input  logic [2:0]           funct3_pi,
    input  logic [4:0]           rd_pi,
    input  logic                 rd_we_pi,
    input  logic [31:0]          alu_result_pi,
    input  logic                 mem_rvalid_pi,
    input  logic [31:0]          mem_rdata_pi,
    output logic [4:0]           destReg_po,
    output logic                 we_po,
    output logic [31:0]          writeData_po,
    output logic                 retire_po,
    output logic                 err_po,
    output logic [CNT_WIDTH-1:0] retire_count_po
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT_LOAD = 1'b1;

    // The timer counts 0..LOAD_TIMEOUT-1; the last value is the final cycle a
    // response can still arrive and win.
    localparam logic [7:0] TIMER_LAST = 8'(LOAD_TIMEOUT - 1);

    logic [0:0]           r_state;
    logic [7:0]           r_timer;
    logic [4:0]           r_ldRd;
    logic                 r_ldWe;
    logic [2:0]           r_ldFunct3;
    logic [1:0]           r_ldOffset;

    logic [4:0]           r_destReg;
    logic                 r_we;
    logic [31:0]          r_writeData;
    logic                 r_retire;
    logic                 r_err;
    logic [CNT_WIDTH-1:0] r_retireCount;

    logic                 w_idle;
    logic                 w_accept;
    logic                 w_loadLegal;
    logic                 w_timeout;
    logic                 w_retireNext;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_loadData;

    assign w_idle    = (r_state == IDLE);
    assign w_accept  = valid_pi & w_idle;
    assign w_timeout = (r_timer == TIMER_LAST);

    // Width/alignment legality of a load, judged on the incoming instruction.
    always_comb begin
        w_loadLegal = 1'b0;
        case (funct3_pi)
            3'b000, 3'b100: w_loadLegal = 1'b1;
            3'b001, 3'b101: w_loadLegal = ~alu_result_pi[0];
            3'b010:         w_loadLegal = (alu_result_pi[1:0] == 2'b00);
            default:        w_loadLegal = 1'b0;
        endcase
    end

    // Select and extend the addressed byte/halfword from the returned word.
    always_comb begin
        w_byte = mem_rdata_pi[7:0];
        case (r_ldOffset)
            2'd0: w_byte = mem_rdata_pi[7:0];
            2'd1: w_byte = mem_rdata_pi[15:8];
            2'd2: w_byte = mem_rdata_pi[23:16];
            2'd3: w_byte = mem_rdata_pi[31:24];
            default: w_byte = mem_rdata_pi[7:0];
        endcase
        w_half = r_ldOffset[1] ? mem_rdata_pi[31:16] : mem_rdata_pi[15:0];
        case (r_ldFunct3)
            3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_loadData = {24'h000000, w_byte};
            3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
            3'b101:  w_loadData = {16'h0000, w_half};
            default: w_loadData = mem_rdata_pi;
        endcase
    end

    // An instruction retires on accept of an ALU op or a faulty load, or on
    // load completion (data or timeout).
    always_comb begin
        w_retireNext = (w_accept & (~is_load_pi | ~w_loadLegal))
                     | (~w_idle & (mem_rvalid_pi | w_timeout));
    end

    // Control state: FSM, load timer and captured load context.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_timer    <= 8'd0;
            r_ldRd     <= 5'd0;
            r_ldWe     <= 1'b0;
            r_ldFunct3 <= 3'd0;
            r_ldOffset <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && is_load_pi && w_loadLegal) begin
                        r_state    <= WAIT_LOAD;
                        r_timer    <= 8'd0;
                        r_ldRd     <= rd_pi;
                        r_ldWe     <= rd_we_pi;
                        r_ldFunct3 <= funct3_pi;
                        r_ldOffset <= alu_result_pi[1:0];
                    end
                end
                WAIT_LOAD: begin
                    if (mem_rvalid_pi || w_timeout) begin
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Registered write port; x0 is never write-enabled so bypass stays clean.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_destReg   <= 5'd0;
            r_we        <= 1'b0;
            r_writeData <= 32'd0;
            r_retire    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_we     <= 1'b0;
            r_retire <= w_retireNext;
            if (w_idle) begin
                if (w_accept && !is_load_pi) begin
                    r_destReg   <= rd_pi;
                    r_writeData <= alu_result_pi;
                    r_we        <= rd_we_pi & (rd_pi != 5'd0);
                end else if (w_accept && !w_loadLegal) begin
                    r_err <= 1'b1;
                end
            end else if (mem_rvalid_pi) begin
                r_destReg   <= r_ldRd;
                r_writeData <= w_loadData;
                r_we        <= r_ldWe & (r_ldRd != 5'd0);
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Retired-instruction counter, wrapping naturally at its width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retireCount <= '0;
        end else if (w_retireNext) begin
            r_retireCount <= r_retireCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign ready_po        = w_idle;
    assign destReg_po      = r_destReg;
    assign we_po           = r_we;
    assign writeData_po    = r_writeData;
    assign retire_po       = r_retire;
    assign err_po          = r_err;
    assign retire_count_po = r_retireCount;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// ALU ops and loads, compared against an arithmetic reference model.
module tb_mem_wb_stage;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        valid_pi;
    logic        ready_po;
    logic        is_load_pi;
    logic [2:0]  funct3_pi;
    logic [4:0]  rd_pi;
    logic        rd_we_pi;
    logic [31:0] alu_result_pi;
    logic        mem_rvalid_pi;
    logic [31:0] mem_rdata_pi;
    logic [4:0]  destReg_po;
    logic        we_po;
    logic [31:0] writeData_po;
    logic        retire_po;
    logic        err_po;
    logic [31:0] retire_count_po;

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the visible outputs should hold.
    logic [31:0] mCount;
    logic        mErr;
    logic [4:0]  mDest;
    logic [31:0] mData;

    mem_wb_stage #(.LOAD_TIMEOUT(TIMEOUT), .CNT_WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_pi        (valid_pi),
        .ready_po        (ready_po),
        .is_load_pi      (is_load_pi),
        .funct3_pi       (funct3_pi),
        .rd_pi           (rd_pi),
        .rd_we_pi        (rd_we_pi),
        .alu_result_pi   (alu_result_pi),
        .mem_rvalid_pi   (mem_rvalid_pi),
        .mem_rdata_pi    (mem_rdata_pi),
        .destReg_po      (destReg_po),
        .we_po           (we_po),
        .writeData_po    (writeData_po),
        .retire_po       (retire_po),
        .err_po          (err_po),
        .retire_count_po (retire_count_po)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packed snapshot of all observable outputs: ready, we, retire, err, dest, data, count.
    function automatic logic [72:0] obs();
        return {ready_po, we_po, retire_po, err_po, destReg_po, writeData_po, retire_count_po};
    endfunction

    function automatic logic [72:0] expv(input logic rdy, input logic we, input logic ret);
        return {rdy, we, ret, mErr, mDest, mData, mCount};
    endfunction

    function automatic bit modelLegal(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (off % 2) == 0;
            3'd2:       return off == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] modelExt(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
        logic [31:0] v;
        int          o;
        o = int'(off);
        case (f3)
            3'd0, 3'd4: begin
                v = (word >> (8 * o)) & 32'h0000_00FF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (word >> (16 * (o / 2))) & 32'h0000_FFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        valid_pi      = 1'b0;
        is_load_pi    = 1'b0;
        funct3_pi     = 3'd0;
        rd_pi         = 5'd0;
        rd_we_pi      = 1'b0;
        alu_result_pi = 32'd0;
        mem_rvalid_pi = 1'b0;
        mem_rdata_pi  = 32'd0;
    endtask

    task automatic applyReset();
        idleInputs();
        reset = 1'b0;
        mCount = 32'd0; mErr = 1'b0; mDest = 5'd0; mData = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        stepCycle();
    endtask

    // One ALU instruction presented for a single cycle.
    task automatic runAlu(input logic [4:0] rd, input logic rdwe, input logic [31:0] data,
                          input string tag);
        valid_pi = 1'b1; is_load_pi = 1'b0; funct3_pi = 3'($urandom);
        rd_pi = rd; rd_we_pi = rdwe; alu_result_pi = data;
        stepCycle();
        valid_pi = 1'b0;
        mDest = rd; mData = data; mCount = mCount + 1;
        checks++;
        if (obs() !== expv(1'b1, rdwe && rd != 0, 1'b1)) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, obs(), expv(1'b1, rdwe && rd != 0, 1'b1));
        end
    endtask

    // One load; delay = wait edge carrying the response (1..TIMEOUT), 0 = never.
    task automatic runLoad(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                           input logic rdwe, input logic [31:0] rdata, input int delay,
                           input string tag);
        int limit;
        logic expWe;
        valid_pi = 1'b1; is_load_pi = 1'b1; funct3_pi = f3;
        rd_pi = rd; rd_we_pi = rdwe; alu_result_pi = ($urandom & 32'hFFFF_FFFC) | {30'd0, off};
        stepCycle();
        valid_pi = 1'b0; is_load_pi = 1'b0;
        if (!modelLegal(f3, off)) begin
            mErr = 1'b1; mCount = mCount + 1;
            checks++;
            if (obs() !== expv(1'b1, 1'b0, 1'b1)) begin
                failures++;
                $display("[TB] FAIL %s-fault actual=%h expected=%h", tag, obs(), expv(1'b1, 1'b0, 1'b1));
            end
        end else begin
            checks++;
            if (obs() !== expv(1'b0, 1'b0, 1'b0)) begin
                failures++;
                $display("[TB] FAIL %s-accept actual=%h expected=%h", tag, obs(), expv(1'b0, 1'b0, 1'b0));
            end
            limit = (delay == 0) ? TIMEOUT : delay;
            for (int k = 1; k <= limit; k++) begin
                mem_rvalid_pi = (k == delay);
                mem_rdata_pi  = (k == delay) ? rdata : $urandom;
                stepCycle();
                mem_rvalid_pi = 1'b0;
                if (k < limit) begin
                    checks++;
                    if (obs() !== expv(1'b0, 1'b0, 1'b0)) begin
                        failures++;
                        $display("[TB] FAIL %s-wait%0d actual=%h expected=%h", tag, k, obs(), expv(1'b0, 1'b0, 1'b0));
                    end
                end
            end
            mCount = mCount + 1;
            if (delay == 0) begin
                mErr  = 1'b1;
                expWe = 1'b0;
            end else begin
                mDest = rd;
                mData = modelExt(f3, off, rdata);
                expWe = rdwe && rd != 0;
            end
            checks++;
            if (obs() !== expv(1'b1, expWe, 1'b1)) begin
                failures++;
                $display("[TB] FAIL %s-done actual=%h expected=%h", tag, obs(), expv(1'b1, expWe, 1'b1));
            end
        end
        stepCycle();
        checks++;
        if (obs() !== expv(1'b1, 1'b0, 1'b0)) begin
            failures++;
            $display("[TB] FAIL %s-hold actual=%h expected=%h", tag, obs(), expv(1'b1, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset();
        applyReset();
        checks++;
        if (obs() !== {1'b1, 72'd0}) begin
            failures++;
            $display("[TB] FAIL reset_state actual=%h expected=%h", obs(), {1'b1, 72'd0});
        end
    endtask

    task automatic test_alu();
        applyReset();
        runAlu(5'd5, 1'b1, 32'hDEADBEEF, "alu_rd5");
        checks++;
        if ({we_po, destReg_po, writeData_po, retire_count_po} !== {1'b1, 5'd5, 32'hDEADBEEF, 32'd1}) begin
            failures++;
            $display("[TB] FAIL alu_const actual=%h expected=%h",
                     {we_po, destReg_po, writeData_po, retire_count_po}, {1'b1, 5'd5, 32'hDEADBEEF, 32'd1});
        end
        stepCycle();
        checks++;
        if (obs() !== expv(1'b1, 1'b0, 1'b0)) begin
            failures++;
            $display("[TB] FAIL alu_pulse actual=%h expected=%h", obs(), expv(1'b1, 1'b0, 1'b0));
        end
        runAlu(5'd0, 1'b1, 32'h1234_5678, "alu_x0");
        for (int i = 0; i < 20; i++) begin
            runAlu(5'($urandom_range(0, 31)), 1'($urandom), $urandom, "alu_rand");
            if ($urandom_range(0, 1) == 1) stepCycle();
        end
    endtask

    task automatic test_back_to_back();
        applyReset();
        runAlu(5'd1, 1'b1, 32'h0000_0011, "b2b_1");
        runAlu(5'd2, 1'b1, 32'h0000_0022, "b2b_2");
        runAlu(5'd3, 1'b1, 32'h0000_0033, "b2b_3");
        stepCycle();
        checks++;
        if (obs() !== expv(1'b1, 1'b0, 1'b0)) begin
            failures++;
            $display("[TB] FAIL b2b_end actual=%h expected=%h", obs(), expv(1'b1, 1'b0, 1'b0));
        end
    endtask

    task automatic test_loads();
        applyReset();
        runLoad(3'd0, 2'd2, 5'd7, 1'b1, 32'h0080FF00, 3, "lb");
        checks++;
        if (writeData_po !== 32'hFFFFFF80) begin
            failures++;
            $display("[TB] FAIL lb_const actual=%h expected=%h", writeData_po, 32'hFFFFFF80);
        end
        runLoad(3'd4, 2'd2, 5'd7, 1'b1, 32'h0080FF00, 3, "lbu");
        checks++;
        if (writeData_po !== 32'h00000080) begin
            failures++;
            $display("[TB] FAIL lbu_const actual=%h expected=%h", writeData_po, 32'h00000080);
        end
        runLoad(3'd1, 2'd2, 5'd9, 1'b1, 32'h8001_1234, 2, "lh");
        checks++;
        if (writeData_po !== 32'hFFFF8001) begin
            failures++;
            $display("[TB] FAIL lh_const actual=%h expected=%h", writeData_po, 32'hFFFF8001);
        end
        runLoad(3'd5, 2'd0, 5'd9, 1'b1, 32'h8001_F234, 1, "lhu");
        runLoad(3'd2, 2'd0, 5'd0, 1'b1, 32'hCAFE_F00D, 1, "lw_x0");
        runLoad(3'd2, 2'd0, 5'd4, 1'b1, 32'hCAFE_F00D, TIMEOUT, "lw_lastcycle");
        runLoad(3'd2, 2'd1, 5'd4, 1'b1, 32'h0, 1, "lw_misaligned");
        runLoad(3'd3, 2'd0, 5'd4, 1'b1, 32'h0, 1, "bad_funct3");
    endtask

    task automatic test_random_loads();
        applyReset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                runAlu(5'($urandom), 1'($urandom), $urandom, "mix_alu");
            else
                runLoad(3'($urandom), 2'($urandom), 5'($urandom), 1'($urandom), $urandom,
                        ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TIMEOUT), "rand_load");
        end
    endtask

    task automatic test_timeout();
        applyReset();
        runLoad(3'd0, 2'd1, 5'd6, 1'b1, 32'h0, 0, "timeout");
        mem_rvalid_pi = 1'b1; mem_rdata_pi = 32'hFFFF_FFFF;
        stepCycle();
        mem_rvalid_pi = 1'b0;
        checks++;
        if (obs() !== expv(1'b1, 1'b0, 1'b0)) begin
            failures++;
            $display("[TB] FAIL late_rvalid actual=%h expected=%h", obs(), expv(1'b1, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset_midload();
        applyReset();
        runAlu(5'd8, 1'b1, 32'hA5A5_0001, "pre_reset_alu");
        valid_pi = 1'b1; is_load_pi = 1'b1; funct3_pi = 3'd2; rd_pi = 5'd8; rd_we_pi = 1'b1;
        alu_result_pi = 32'h0000_0100;
        stepCycle();
        idleInputs();
        repeat (2) stepCycle();
        #2 reset = 1'b0;
        #1;
        mCount = 32'd0; mErr = 1'b0; mDest = 5'd0; mData = 32'd0;
        checks++;
        if (obs() !== {1'b1, 72'd0}) begin
            failures++;
            $display("[TB] FAIL async_reset actual=%h expected=%h", obs(), {1'b1, 72'd0});
        end
        @(negedge clk);
        reset = 1'b1;
        stepCycle();
        mem_rvalid_pi = 1'b1; mem_rdata_pi = 32'h1111_2222;
        stepCycle();
        mem_rvalid_pi = 1'b0;
        checks++;
        if (obs() !== expv(1'b1, 1'b0, 1'b0)) begin
            failures++;
            $display("[TB] FAIL post_reset_rvalid actual=%h expected=%h", obs(), expv(1'b1, 1'b0, 1'b0));
        end
    endtask

    initial begin
        reset = 1'b0;
        idleInputs();
        test_reset();
        test_alu();
        test_back_to_back();
        test_loads();
        test_timeout();
        test_random_loads();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
